// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler
//   Buffers upstream DAC codes in a small FIFO and releases exactly one code
//   every PERIOD clocks to a delta-sigma DAC, so the output sample rate stays
//   fixed however bursty the upstream producer is.
//
// Parameters
//   WIDTH  - code width of the DAC input
//   DEPTH  - FIFO entries (power of two, >= 2)
//   PERIOD - clocks per DAC update (>= 2)
//
// Ports
//   clk           - system clock, rising edge
//   rst           - synchronous active-high reset
//   enable        - run request for sample playout
//   s_valid/s_data/s_ready - upstream sample handshake
//   DAC_in        - registered code driving the DAC
//   sample_strobe - one-cycle pulse on every DAC_in update
//   underrun      - sticky: a playout tick found the FIFO empty
//   underrun_clr  - clears underrun (a simultaneous set wins)
//   fifo_level    - current FIFO occupancy
module dac_sample_scheduler #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 4,
    parameter int PERIOD = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       s_valid,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       s_ready,
    output logic [WIDTH-1:0]           DAC_in,
    output logic                       sample_strobe,
    output logic                       underrun,
    input  logic                       underrun_clr,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_UNDERRUN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    level_q, level_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dac_q;
    logic             strobe_q;
    logic             underrun_q, underrun_d;

    logic             push_s;
    logic             pop_s;
    logic             empty_tick_s;
    logic             tick_s;
    logic             not_empty_s;

    // Ready comes only from the registered level, so a pop while full cannot
    // open the input in the same cycle.
    assign s_ready     = (level_q < LW'(DEPTH));
    assign push_s      = s_valid && s_ready;
    assign not_empty_s = (level_q != {LW{1'b0}});
    assign tick_s      = (cnt_q == CW'(PERIOD - 1));

    // Playout FSM: decides pops, underrun ticks and the period counter.
    // Pops look at the registered level, so a sample pushed on a tick into an
    // empty FIFO waits for the next tick.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pop_s        = 1'b0;
        empty_tick_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (enable && not_empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_UNDERRUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (tick_s) begin
                    cnt_d = {CW{1'b0}};
                    if (not_empty_s) begin
                        pop_s   = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        empty_tick_s = 1'b1;
                        state_d      = ST_UNDERRUN;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Occupancy update; simultaneous push and pop cancel out.
    always_comb begin
        level_d = level_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Sticky underrun: a new empty tick beats a coincident clear.
    always_comb begin
        if (empty_tick_s) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            level_q    <= {LW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            dac_q      <= {WIDTH{1'b0}};
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            strobe_q   <= pop_s;
            underrun_q <= underrun_d;
            // Pointers are PW bits wide, so they wrap modulo DEPTH naturally.
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                dac_q    <= mem_q[rd_ptr_q];
            end
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign DAC_in        = dac_q;
    assign sample_strobe = strobe_q;
    assign underrun      = underrun_q;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Self-checking bench for dac_sample_scheduler (WIDTH=10, DEPTH=4, PERIOD=8).
// A queue-based reference model predicts every output each cycle; directed
// literal checks pin the model at the key scenario points.
module tb_dac_sample_scheduler;

    localparam int W   = 10;
    localparam int DEP = 4;
    localparam int PER = 8;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;
    logic [W-1:0] DAC_in;
    logic         sample_strobe;
    logic         underrun;
    logic         underrun_clr;
    logic [2:0]   fifo_level;

    int checks;
    int errors;

    dac_sample_scheduler #(.WIDTH(W), .DEPTH(DEP), .PERIOD(PER)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .DAC_in        (DAC_in),
        .sample_strobe (sample_strobe),
        .underrun      (underrun),
        .underrun_clr  (underrun_clr),
        .fifo_level    (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] mq[$];
    bit           m_run;
    int           m_ph;
    logic [W-1:0] m_dac;
    bit           m_stb;
    bit           m_und;
    bit           m_ok;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of the reference: ticks fall every PER cycles after playout
    // starts; playout stops when enable drops.
    task automatic model_step();
        int lvl;
        bit popd;
        bit et;
        if (rst) begin
            mq.delete();
            m_run = 1'b0;
            m_ph  = 0;
            m_dac = '0;
            m_stb = 1'b0;
            m_und = 1'b0;
            m_ok  = 1'b1;
            return;
        end
        lvl  = mq.size();
        popd = 1'b0;
        et   = 1'b0;
        if (!m_run) begin
            if (enable && lvl > 0) begin
                popd  = 1'b1;
                m_run = 1'b1;
                m_ph  = 0;
            end
        end else if (!enable) begin
            m_run = 1'b0;
            m_ph  = 0;
        end else if (m_ph == PER - 1) begin
            m_ph = 0;
            if (lvl > 0) popd = 1'b1;
            else et = 1'b1;
        end else begin
            m_ph++;
        end
        if (popd) m_dac = mq.pop_front();
        if (s_valid && lvl < DEP) mq.push_back(s_data);
        m_stb = popd;
        if (et) m_und = 1'b1;
        else if (underrun_clr) m_und = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            cyc();
            if (sample_strobe === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic stimulus();
        int n;
        // Reset
        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; underrun_clr = 1'b0;
        repeat (2) cyc();
        chk("rst_dac", 32'(DAC_in), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_strobe", 32'(sample_strobe), 32'd0);
        rst = 1'b0;

        // Playout of three samples
        s_valid = 1'b1; s_data = 10'h3FF; cyc();
        s_data = 10'h200; cyc();
        s_data = 10'h000; cyc();
        s_valid = 1'b0;
        chk("play_level", 32'(fifo_level), 32'd3);
        enable = 1'b1; cyc();
        chk("play0_dac", 32'(DAC_in), 32'h3FF);
        chk("play0_strobe", 32'(sample_strobe), 32'd1);
        wait_strobe(20, n);
        chk("play1_gap", 32'(n), 32'd8);
        chk("play1_dac", 32'(DAC_in), 32'h200);
        wait_strobe(20, n);
        chk("play2_gap", 32'(n), 32'd8);
        chk("play2_dac", 32'(DAC_in), 32'h000);

        // Underrun then late sample played on following tick only
        repeat (8) cyc();
        chk("und_flag", 32'(underrun), 32'd1);
        chk("und_strobe", 32'(sample_strobe), 32'd0);
        chk("und_dac", 32'(DAC_in), 32'h000);
        repeat (3) cyc();
        s_valid = 1'b1; s_data = 10'h155; cyc();
        s_valid = 1'b0;
        wait_strobe(20, n);
        chk("recover_gap", 32'(n), 32'd4);
        chk("recover_dac", 32'(DAC_in), 32'h155);
        chk("recover_und_sticky", 32'(underrun), 32'd1);

        // Clear, then set/clear collision on the next empty tick
        underrun_clr = 1'b1; cyc();
        underrun_clr = 1'b0;
        chk("clr_flag", 32'(underrun), 32'd0);
        repeat (6) cyc();
        underrun_clr = 1'b1; cyc();
        chk("collide_set_wins", 32'(underrun), 32'd1);
        cyc();
        underrun_clr = 1'b0;
        chk("collide_clr_after", 32'(underrun), 32'd0);

        // Reset mid-run with two samples queued
        s_valid = 1'b1; s_data = 10'h011; cyc();
        s_data = 10'h022; cyc();
        s_data = 10'h033; cyc();
        s_valid = 1'b0;
        wait_strobe(20, n);
        chk("midrun_dac", 32'(DAC_in), 32'h011);
        chk("midrun_level", 32'(fifo_level), 32'd2);
        rst = 1'b1; cyc();
        rst = 1'b0;
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_dac", 32'(DAC_in), 32'h0);
        chk("midrst_strobe", 32'(sample_strobe), 32'd0);
        chk("midrst_ready", 32'(s_ready), 32'd1);
        wait_strobe(12, n);
        chk("empty_enable_nostrobe", 32'(n), 32'hFFFF_FFFF);

        // Full FIFO: fifth push refused and never played
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = W'(10'h101 + i); cyc();
            if (i == 3) begin
                chk("full_ready", 32'(s_ready), 32'd0);
                chk("full_level4", 32'(fifo_level), 32'd4);
            end
        end
        s_valid = 1'b0;
        chk("full_level5", 32'(fifo_level), 32'd4);
        enable = 1'b1; cyc();
        chk("full_play0", 32'(DAC_in), 32'h101);
        for (int k = 1; k < 4; k++) begin
            wait_strobe(20, n);
            chk("full_gap", 32'(n), 32'd8);
            chk("full_dac", 32'(DAC_in), 32'(10'h101 + k));
        end
        wait_strobe(12, n);
        chk("fifth_never", 32'(n), 32'hFFFF_FFFF);
        chk("fifth_dac_held", 32'(DAC_in), 32'h104);
        chk("fifth_underrun", 32'(underrun), 32'd1);
        repeat (2) cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ok   = 1'b0;
        fork
            stimulus();
            forever begin
                @(posedge clk);
                model_step();
            end
            forever begin
                @(negedge clk);
                if (m_ok) begin
                    chk("m_dac", 32'(DAC_in), 32'(m_dac));
                    chk("m_strobe", 32'(sample_strobe), 32'(m_stb));
                    chk("m_underrun", 32'(underrun), 32'(m_und));
                    chk("m_level", 32'(fifo_level), 32'(mq.size()));
                    chk("m_ready", 32'(s_ready), 32'(mq.size() < DEP));
                end
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
